uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 16x oversampled, mid-bit sampling, false-start and break rejection.
// Latency: SYNC_STAGES clk + <=1 tick (start detect) + 152 ticks + 1 clk from start edge to rx_done.
// Backpressure: none; rx_data is held until the next rx_done and a consumer must take each pulse.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   rst        synchronous active-high reset
//   b_tick     one-clk pulse at 16x the baud rate
//   rx         asynchronous serial line, idle high
//   rx_data    last received byte, held until the next rx_done
//   rx_done    one-clk pulse when rx_data/frame_err are updated
//   rx_busy    high from start-bit detection to frame end or false-start rejection
//   frame_err  stop-bit status of the last frame (1 = stop bit read as 0)

module uart_rx #(
  parameter int SYNC_STAGES = 2  // must be >= 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchronizer resets to all ones so the idle line is not mistaken for a start bit.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  state_t     state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  // Cleared by a framing error so a held-low line (break) is not re-read as
  // an endless stream of start bits; re-armed once the line is seen high.
  logic       armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      armed     <= 1'b1;
    end else begin
      rx_done <= 1'b0;
      if (b_tick) begin
        case (state)
          IDLE: begin
            if (!rx_s && armed) begin
              state    <= START;
              tick_cnt <= 4'd0;
              rx_busy  <= 1'b1;
            end else if (rx_s) begin
              armed <= 1'b1;
            end
          end

          START: begin
            if (tick_cnt == 4'd7) begin
              // Mid start bit: a high line here means the edge was a glitch.
              if (rx_s) begin
                state    <= IDLE;
                rx_busy  <= 1'b0;
                tick_cnt <= 4'd0;
              end else begin
                state    <= DATA;
                tick_cnt <= 4'd0;
                bit_cnt  <= 3'd0;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          DATA: begin
            if (tick_cnt == 4'd15) begin
              // LSB first: each new bit enters at the MSB and moves right.
              shreg    <= {rx_s, shreg[7:1]};
              tick_cnt <= 4'd0;
              if (bit_cnt == 3'd7) begin
                state <= STOP;
              end
              bit_cnt <= bit_cnt + 3'd1;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          STOP: begin
            if (tick_cnt == 4'd15) begin
              // Byte is delivered even on a bad stop bit; frame_err flags it.
              rx_data   <= shreg;
              rx_done   <= 1'b1;
              frame_err <= ~rx_s;
              armed     <= rx_s;
              rx_busy   <= 1'b0;
              tick_cnt  <= 4'd0;
              state     <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       b_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .b_tick    (b_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  typedef struct {
    logic [7:0] d;
    logic       fe;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   tick_div = 3;
  int   tick_ctr = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: one-clk pulse every tick_div clocks, changed on the falling edge.
  initial begin
    b_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_ctr >= tick_div - 1) begin
        b_tick   = 1'b1;
        tick_ctr = 0;
      end else begin
        b_tick   = 1'b0;
        tick_ctr = tick_ctr + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor / scoreboard consumer.
  initial begin
    logic       r;
    logic [7:0] prev_d;
    logic       prev_fe;
    exp_t       e;
    prev_d  = 8'h00;
    prev_fe = 1'b0;
    forever begin
      @(posedge clk);
      r = rst;
      @(negedge clk);
      if (rx_done === 1'b1) begin
        done_cnt++;
        check("sb_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.d));
          check("frame_err", 32'(frame_err), 32'(e.fe));
          check("busy_at_done", 32'(rx_busy), 32'd0);
        end
      end else if (!r) begin
        check("data_hold", 32'({frame_err, rx_data}), 32'({prev_fe, prev_d}));
      end
      prev_d  = rx_data;
      prev_fe = frame_err;
    end
  end

  initial begin
    #950us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (b_tick !== 1'b1);
    end
    @(negedge clk);
  endtask

  // Transmitter model driven from the shared tick; leaves rx at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = stop;
    wait_ticks(16);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic fe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 5000 && q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int  base;
    logic busy_seen;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_done", 32'(rx_done), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    rst = 1'b0;
    wait_ticks(32);

    // Clean frame 0xA5.
    base = done_cnt;
    expect_frame(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1);
    wait_drain();
    wait_ticks(16);
    check("a5_one_done", 32'(done_cnt - base), 32'd1);
    check("a5_busy_low", 32'(rx_busy), 32'd0);

    // 4-tick low glitch: false start, busy rises then falls, no byte.
    base      = done_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_ticks(1);
      if (rx_busy) busy_seen = 1'b1;
    end
    rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wait_ticks(1);
      if (rx_busy) busy_seen = 1'b1;
    end
    check("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check("glitch_busy_low", 32'(rx_busy), 32'd0);
    check("glitch_no_done", 32'(done_cnt - base), 32'd0);

    // Framing error followed by a 40-bit-time break, then a valid frame.
    base = done_cnt;
    expect_frame(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b0);
    wait_ticks(39 * 16);
    check("break_one_done", 32'(done_cnt - base), 32'd1);
    check("break_busy", 32'(rx_busy), 32'd0);
    check("break_hold", 32'({frame_err, rx_data}), 32'h13C);
    rx = 1'b1;
    wait_ticks(32);
    expect_frame(8'h81, 1'b0);
    send_frame(8'h81, 1'b1);
    wait_drain();
    check("after_break_cnt", 32'(done_cnt - base), 32'd2);

    // Back-to-back frames with no idle gap.
    base = done_cnt;
    expect_frame(8'h00, 1'b0);
    expect_frame(8'hFF, 1'b0);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_drain();
    check("b2b_cnt", 32'(done_cnt - base), 32'd2);
    wait_ticks(32);

    // Reset during data bit 4, held until the line is idle again.
    base = done_cnt;
    fork
      send_frame(8'hC3, 1'b1);
      begin
        wait_ticks(16 * 5 + 8);
        rst = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    rst = 1'b0;
    wait_ticks(32);
    check("midrst_no_done", 32'(done_cnt - base), 32'd0);
    check("midrst_data", 32'(rx_data), 32'h00);
    check("midrst_busy", 32'(rx_busy), 32'd0);
    expect_frame(8'h5A, 1'b0);
    send_frame(8'h5A, 1'b1);
    wait_drain();

    // Loopback sweep at one tick per clock.
    tick_div = 1;
    wait_ticks(32);
    base = done_cnt;
    for (int i = 0; i < 256; i++) begin
      expect_frame(8'(i), 1'b0);
      send_frame(8'(i), 1'b1);
    end
    wait_drain();
    check("sweep_cnt", 32'(done_cnt - base), 32'd256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
